// File: rtl/hbridge_ramp_ctrl.sv
// Command sequencer for a locked-anti-phase H-bridge: ramps hi-time toward commanded targets in bounded steps.
// Optional build macro HBRIDGE_RAMP_CTRL_FAULT_LATCH_EN makes FAULT sticky until i_fault_clr.
module hbridge_ramp_ctrl #(
    parameter int DWID = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [DWID-1:0] i_cmd_target,
    input  logic            i_cmd_stop,
    input  logic [DWID-1:0] i_period,
    input  logic [DWID-1:0] i_step,
    input  logic [DWID-1:0] i_step_interval,
    input  logic            i_fault,
    input  logic            i_fault_clr,
    output logic            o_enable,
    output logic [DWID-1:0] o_period,
    output logic [DWID-1:0] o_hi_time,
    output logic [1:0]      o_state,
    output logic            o_at_target,
    output logic            o_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_enable, w_enable_nx;
    logic [DWID-1:0] r_period, w_period_nx;
    logic [DWID-1:0] r_hi_time, w_hi_time_nx;
    logic [DWID-1:0] r_target, w_target_nx;
    logic            r_stop_pending, w_stop_pending_nx;
    logic [DWID-1:0] r_tick_cnt, w_tick_cnt_nx;

    logic            w_accept;
    logic [DWID-1:0] w_mid;
    logic [DWID-1:0] w_new_mid;
    logic [DWID-1:0] w_cmd_target;
    logic [DWID-1:0] w_step;
    logic [DWID-1:0] w_interval;
    logic            w_tick;
    logic [DWID:0]   w_up;
    logic [DWID:0]   w_gap_dn;
    logic [DWID-1:0] w_hi_stepped;

    // Handshake: a command transfers on any edge where i_cmd_valid && o_cmd_ready;
    // ready is a pure decode of state and drops only while in FAULT.
    assign o_cmd_ready = (r_state != S_FAULT);
    assign w_accept    = i_cmd_valid && o_cmd_ready;

    assign w_mid        = r_period >> 1;
    assign w_new_mid    = i_period >> 1;
    assign w_cmd_target = i_cmd_stop ? w_new_mid :
                          ((i_cmd_target < i_period) ? i_cmd_target : i_period);
    assign w_step       = (i_step == '0) ? DWID'(1) : i_step;
    assign w_interval   = (i_step_interval == '0) ? DWID'(1) : i_step_interval;
    assign w_tick       = (r_tick_cnt >= (w_interval - DWID'(1)));

    // One extra bit keeps the step arithmetic from wrapping near 0 or all-ones.
    assign w_up     = {1'b0, r_hi_time} + {1'b0, w_step};
    assign w_gap_dn = {1'b0, r_hi_time} - {1'b0, r_target};

    always_comb begin
        w_hi_stepped = r_target;
        if (r_hi_time < r_target) begin
            if (w_up < {1'b0, r_target}) w_hi_stepped = w_up[DWID-1:0];
        end else if (r_hi_time > r_target) begin
            if (w_gap_dn > {1'b0, w_step}) w_hi_stepped = r_hi_time - w_step;
        end
    end

    always_comb begin
        w_state_nx        = r_state;
        w_enable_nx       = r_enable;
        w_period_nx       = r_period;
        w_hi_time_nx      = r_hi_time;
        w_target_nx       = r_target;
        w_stop_pending_nx = r_stop_pending;
        w_tick_cnt_nx     = r_tick_cnt;
        if (i_fault) begin
            w_state_nx        = S_FAULT;
            w_enable_nx       = 1'b0;
            w_hi_time_nx      = w_mid;
            w_target_nx       = '0;
            w_stop_pending_nx = 1'b0;
            w_tick_cnt_nx     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_enable_nx  = 1'b0;
                    w_period_nx  = i_period;
                    w_hi_time_nx = w_new_mid;
                    if (w_accept && !i_cmd_stop) begin
                        w_state_nx        = S_RAMP;
                        w_enable_nx       = 1'b1;
                        w_target_nx       = w_cmd_target;
                        w_stop_pending_nx = 1'b0;
                        w_tick_cnt_nx     = '0;
                    end
                end
                S_RAMP, S_HOLD: begin
                    if (w_accept) begin
                        // A new command drops any tick due on this edge.
                        w_state_nx        = S_RAMP;
                        w_period_nx       = i_period;
                        w_target_nx       = w_cmd_target;
                        w_stop_pending_nx = i_cmd_stop;
                        w_tick_cnt_nx     = '0;
                    end else if (r_state == S_RAMP) begin
                        if (w_tick) begin
                            w_tick_cnt_nx = '0;
                            w_hi_time_nx  = w_hi_stepped;
                            if (w_hi_stepped == r_target) begin
                                if (r_stop_pending) begin
                                    w_state_nx        = S_IDLE;
                                    w_enable_nx       = 1'b0;
                                    w_stop_pending_nx = 1'b0;
                                end else begin
                                    w_state_nx = S_HOLD;
                                end
                            end
                        end else begin
                            w_tick_cnt_nx = r_tick_cnt + DWID'(1);
                        end
                    end
                end
                default: begin
`ifdef HBRIDGE_RAMP_CTRL_FAULT_LATCH_EN
                    if (i_fault_clr) w_state_nx = S_IDLE;
`else
                    w_state_nx = S_IDLE;
`endif
                end
            endcase
        end
    end

`ifndef HBRIDGE_RAMP_CTRL_FAULT_LATCH_EN
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = i_fault_clr;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_enable       <= 1'b0;
            r_period       <= '0;
            r_hi_time      <= '0;
            r_target       <= '0;
            r_stop_pending <= 1'b0;
            r_tick_cnt     <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_enable       <= w_enable_nx;
            r_period       <= w_period_nx;
            r_hi_time      <= w_hi_time_nx;
            r_target       <= w_target_nx;
            r_stop_pending <= w_stop_pending_nx;
            r_tick_cnt     <= w_tick_cnt_nx;
        end
    end

    assign o_enable    = r_enable;
    assign o_period    = r_period;
    assign o_hi_time   = r_hi_time;
    assign o_state     = r_state;
    assign o_at_target = (r_state == S_HOLD);
    assign o_fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_hbridge_ramp_ctrl.sv
// Directed bench for hbridge_ramp_ctrl; covers both builds of HBRIDGE_RAMP_CTRL_FAULT_LATCH_EN.
module tb_hbridge_ramp_ctrl;

    localparam int DWID = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [DWID-1:0] i_cmd_target;
    logic            i_cmd_stop;
    logic [DWID-1:0] i_period;
    logic [DWID-1:0] i_step;
    logic [DWID-1:0] i_step_interval;
    logic            i_fault;
    logic            i_fault_clr;
    logic            o_enable;
    logic [DWID-1:0] o_period;
    logic [DWID-1:0] o_hi_time;
    logic [1:0]      o_state;
    logic            o_at_target;
    logic            o_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hbridge_ramp_ctrl #(.DWID(DWID)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_target    (i_cmd_target),
        .i_cmd_stop      (i_cmd_stop),
        .i_period        (i_period),
        .i_step          (i_step),
        .i_step_interval (i_step_interval),
        .i_fault         (i_fault),
        .i_fault_clr     (i_fault_clr),
        .o_enable        (o_enable),
        .o_period        (o_period),
        .o_hi_time       (o_hi_time),
        .o_state         (o_state),
        .o_at_target     (o_at_target),
        .o_fault         (o_fault)
    );

    task automatic chk(input string tag, input logic [DWID-1:0] obs, input logic [DWID-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge (cycle N+1).
    task automatic send_cmd(input logic [DWID-1:0] tgt, input logic stop);
        i_cmd_valid  = 1'b1;
        i_cmd_target = tgt;
        i_cmd_stop   = stop;
        @(posedge clk);
        #1;
        i_cmd_valid  = 1'b0;
        i_cmd_stop   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_target = '0; i_cmd_stop = 1'b0;
        i_period = 1000; i_step = 10; i_step_interval = 4;
        i_fault = 1'b0; i_fault_clr = 1'b0;
        step_n(2);
        chk("rst_state", DWID'(o_state), 0);
        chk("rst_enable", DWID'(o_enable), 0);
        chk("rst_period", o_period, 0);
        chk("rst_hi", o_hi_time, 0);
        chk("rst_ready", DWID'(o_cmd_ready), 1);
        chk("rst_at_target", DWID'(o_at_target), 0);
        chk("rst_fault", DWID'(o_fault), 0);
        rst = 1'b1;
        step_n(1);
        chk("idle_period", o_period, 1000);
        chk("idle_hi", o_hi_time, 500);
        chk("idle_enable", DWID'(o_enable), 0);

        // Ramp up 500 -> 800, step 10 every 4 cycles
        send_cmd(800, 1'b0);
        chk("up_enable", DWID'(o_enable), 1);
        chk("up_state", DWID'(o_state), 1);
        chk("up_hi_n1", o_hi_time, 500);
        step_n(4);
        chk("up_hi_n5", o_hi_time, 510);
        step_n(115);
        chk("up_hi_n120", o_hi_time, 790);
        chk("up_state_n120", DWID'(o_state), 1);
        step_n(1);
        chk("up_hi_n121", o_hi_time, 800);
        chk("up_state_n121", DWID'(o_state), 2);
        chk("up_at_target", DWID'(o_at_target), 1);

        // Stop from HOLD: ramp back to 500, then IDLE on the same edge
        send_cmd(0, 1'b1);
        chk("stop_hi_n1", o_hi_time, 800);
        chk("stop_state_n1", DWID'(o_state), 1);
        step_n(116);
        chk("stop_hi_n117", o_hi_time, 510);
        chk("stop_enable_n117", DWID'(o_enable), 1);
        step_n(4);
        chk("stop_hi_n121", o_hi_time, 500);
        chk("stop_state_n121", DWID'(o_state), 0);
        chk("stop_enable_n121", DWID'(o_enable), 0);

        send_cmd(0, 1'b1);
        chk("idle_stop_state", DWID'(o_state), 0);
        chk("idle_stop_enable", DWID'(o_enable), 0);

        // Saturation at 805 and clamp of 1500 to the period
        send_cmd(805, 1'b0);
        step_n(120);
        chk("sat_hi_n121", o_hi_time, 800);
        chk("sat_state_n121", DWID'(o_state), 1);
        step_n(4);
        chk("sat_hi_n125", o_hi_time, 805);
        chk("sat_state_n125", DWID'(o_state), 2);
        send_cmd(1500, 1'b0);
        chk("clamp_hi_n1", o_hi_time, 805);
        step_n(76);
        chk("clamp_hi_n77", o_hi_time, 995);
        chk("clamp_state_n77", DWID'(o_state), 1);
        step_n(4);
        chk("clamp_hi_n81", o_hi_time, 1000);
        chk("clamp_state_n81", DWID'(o_state), 2);

        // Fast stop with large step and interval 1
        i_step = 100; i_step_interval = 1;
        send_cmd(0, 1'b1);
        chk("fstop_hi_n1", o_hi_time, 1000);
        step_n(1);
        chk("fstop_hi_n2", o_hi_time, 900);
        step_n(4);
        chk("fstop_hi_n6", o_hi_time, 500);
        chk("fstop_state_n6", DWID'(o_state), 0);

        // Zero step and zero interval both behave as 1
        i_step = 0; i_step_interval = 0;
        send_cmd(503, 1'b0);
        chk("zero_hi_n1", o_hi_time, 500);
        step_n(1);
        chk("zero_hi_n2", o_hi_time, 501);
        step_n(2);
        chk("zero_hi_n4", o_hi_time, 503);
        chk("zero_state_n4", DWID'(o_state), 2);
        send_cmd(0, 1'b1);
        step_n(3);
        chk("zero_stop_state", DWID'(o_state), 0);

        // Retarget at 600 on a cycle where a tick is due: tick is dropped
        i_step = 10; i_step_interval = 4;
        send_cmd(800, 1'b0);
        step_n(43);
        chk("rt_hi_before", o_hi_time, 600);
        send_cmd(300, 1'b0);
        chk("rt_hi_n1", o_hi_time, 600);
        chk("rt_state_n1", DWID'(o_state), 1);
        step_n(4);
        chk("rt_hi_n5", o_hi_time, 590);
        step_n(4);
        chk("rt_hi_n9", o_hi_time, 580);
        step_n(108);
        chk("rt_hi_n117", o_hi_time, 310);
        chk("rt_state_n117", DWID'(o_state), 1);
        step_n(4);
        chk("rt_hi_n121", o_hi_time, 300);
        chk("rt_state_n121", DWID'(o_state), 2);

        // Fault mid-ramp
        send_cmd(800, 1'b0);
        step_n(10);
        chk("flt_hi_before", o_hi_time, 320);
        i_fault = 1'b1;
        step_n(1);
        chk("flt_enable", DWID'(o_enable), 0);
        chk("flt_hi", o_hi_time, 500);
        chk("flt_state", DWID'(o_state), 3);
        chk("flt_ready", DWID'(o_cmd_ready), 0);
        chk("flt_fault", DWID'(o_fault), 1);
        i_cmd_valid = 1'b1; i_cmd_target = 800;
        step_n(1);
        i_cmd_valid = 1'b0;
        chk("flt_cmd_state", DWID'(o_state), 3);
        chk("flt_cmd_enable", DWID'(o_enable), 0);
`ifdef HBRIDGE_RAMP_CTRL_FAULT_LATCH_EN
        i_fault_clr = 1'b1;
        step_n(1);
        i_fault_clr = 1'b0;
        chk("flt_clr_ignored", DWID'(o_state), 3);
        i_fault = 1'b0;
        step_n(2);
        chk("flt_latched", DWID'(o_state), 3);
        chk("flt_latched_fault", DWID'(o_fault), 1);
        i_fault_clr = 1'b1;
        step_n(1);
        i_fault_clr = 1'b0;
`else
        i_fault = 1'b0;
        step_n(1);
`endif
        chk("flt_exit_state", DWID'(o_state), 0);
        chk("flt_exit_fault", DWID'(o_fault), 0);
        chk("flt_exit_ready", DWID'(o_cmd_ready), 1);

        // IDLE tracks a new period
        i_period = 600;
        step_n(1);
        chk("track_period", o_period, 600);
        chk("track_hi", o_hi_time, 300);

        // Reset mid-ramp
        i_period = 1000;
        step_n(1);
        send_cmd(800, 1'b0);
        step_n(10);
        chk("mr_hi_before", o_hi_time, 520);
        rst = 1'b0;
        step_n(1);
        chk("mr_state", DWID'(o_state), 0);
        chk("mr_enable", DWID'(o_enable), 0);
        chk("mr_period", o_period, 0);
        chk("mr_hi", o_hi_time, 0);
        chk("mr_ready", DWID'(o_cmd_ready), 1);
        chk("mr_at_target", DWID'(o_at_target), 0);
        rst = 1'b1;
        step_n(1);
        chk("mr_track_period", o_period, 1000);
        chk("mr_track_hi", o_hi_time, 500);
        chk("mr_track_state", DWID'(o_state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hbridge_ramp_ctrl.md
# hbridge_ramp_ctrl

Command sequencer for the Locked-Anti-Phase H-bridge driver. It accepts target duty commands over a valid/ready handshake and ramps the bridge hi-time toward each target in bounded steps, avoiding current spikes. Stop commands ramp back to zero current (50 % duty) and then disable the bridge. A fault input forces the bridge off immediately. The block drives the bridge's enable, period and hi-time inputs directly.

## Interface
- DWID, 32, width of period / hi-time / step arithmetic
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_cmd_target  in  DWID  requested hi-time (clk cycles)
- i_cmd_stop  in  1  1 = stop command (target ignored)
- i_period  in  DWID  PWM period; latched at command accept
- i_step  in  DWID  hi-time change per ramp tick; 0 treated as 1
- i_step_interval  in  DWID  cycles between ramp ticks; 0 treated as 1
- i_fault  in  1  overcurrent/fault, level-sensitive
- i_fault_clr  in  1  fault clear pulse
- o_enable  out  1  to bridge i_enable
- o_period  out  DWID  latched period, to bridge i_period
- o_hi_time  out  DWID  to bridge i_hi_time
- o_state  out  2  0 IDLE, 1 RAMP, 2 HOLD, 3 FAULT
- o_at_target  out  1  high in HOLD
- o_fault  out  1  high in FAULT

## Operation
- mid = o_period >> 1, the zero-current point. All outputs are registered except o_cmd_ready and o_at_target/o_fault, which decode the state.
- **IDLE:** o_enable=0. o_period tracks i_period and o_hi_time tracks i_period>>1 every cycle.
- **Accept (any state except FAULT):** o_cmd_ready = (state != FAULT).
  - On accept, latch i_period into o_period.
  - target = stop ? mid : min(i_cmd_target, i_period).
  - Set stop_pending = i_cmd_stop, clear the tick counter and go to RAMP.
  - From IDLE, also set o_enable=1 with o_hi_time=mid. A stop accepted in IDLE stays IDLE with no effect.
- **RAMP:**
  - Tick counter fires every max(i_step_interval,1) cycles.
  - On a tick, o_hi_time moves toward the target by max(i_step,1), saturating at the target with no overshoot. Arithmetic is DWID+1 bits, so there is no wrap at 0 or at 2^DWID-1.
  - On the edge where o_hi_time becomes the target: go to IDLE with o_enable=0 if stop_pending, else go to HOLD.
- **HOLD:** o_hi_time is constant. A new command re-enters RAMP from the present hi-time.
- **Retarget in RAMP:** the ramp continues from the present o_hi_time toward the new target. The counter restarts.
- **FAULT:**
  - Entry: i_fault=1 in any state takes effect on the next edge. o_enable=0, o_hi_time=mid, and counter, target and stop_pending are cleared.
  - Exit: see Configuration. Exit is always to IDLE.
- **Priority:** reset > fault > command accept > ramp tick. If a command and a tick occur in the same cycle, the command wins and the tick is dropped.

## Timing
- **Reset values:** state IDLE, o_enable=0, o_period=0, o_hi_time=0, o_state=0, o_at_target=0, o_fault=0, o_cmd_ready=1 (decoded). IDLE tracking starts on the first post-reset edge.
- **Accept at cycle N:**
  - o_enable=1, o_state=RAMP and o_hi_time=mid (from IDLE) at N+1.
  - Step k applies at N+1+k·max(i_step_interval,1).
- **Step count:** a ramp of distance D takes ceil(D/step) ticks.
- **Fault latency:** i_fault sampled high at N gives o_enable=0 at N+1.
- **Reset mid-operation:** all outputs return to reset values on the next edge.

## Configuration
- Macro: HBRIDGE_RAMP_CTRL_FAULT_LATCH_EN.
- **Defined:** FAULT is latched. Exit to IDLE only on a cycle with i_fault_clr=1 and i_fault=0. i_fault_clr while i_fault=1 is ignored.
- **Undefined:** FAULT auto-recovers to IDLE on the first cycle i_fault=0. i_fault_clr is unused.

## Test plan
- **Ramp up:** period=1000, step=10, interval=4, target=800, accept at N.
  - Expect enable=1 and hi_time=500 at N+1, and 510 at N+5.
  - Expect 800 with HOLD at N+121.
- **Saturation:** same setup, target=805.
  - Expect 31 ticks, final hi_time=805 (not 810), then HOLD.
  - Clamp check: target=1500 with period=1000 gives target 1000.
- **Stop:** from HOLD at 800, stop command.
  - Expect ramp down to 500 in 30 ticks.
  - On that same edge, expect state=IDLE and enable=0.
- **Retarget:** while ramping up at hi_time=600, command target=300.
  - Expect hi_time to fall 590, 580, … to 300, then HOLD.
  - Also: a command and a tick in the same cycle drops the tick.
- **Fault:** i_fault=1 mid-ramp at N.
  - Expect enable=0, hi_time=500, state=FAULT and ready=0 at N+1.
  - Latch defined: stays FAULT after i_fault falls, reaches IDLE only after i_fault_clr.
  - Latch undefined: reaches IDLE one cycle after i_fault falls.
- **Reset:** rst=0 mid-ramp.
  - Expect all outputs at reset values next edge.
  - Expect IDLE tracking of i_period>>1 after release.
